// File: rtl/mt_core_pkg.sv
// Shared decode definitions for the multithreaded RV32 core: opcodes, control
// encodings and the thread-index width helper.
package mt_core_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} res_src_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_type_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    // Control fields carried into execute.
    typedef struct packed {
        logic     reg_write;
        res_src_t res_src;
        logic     mem_write;
        logic     jump;
        logic     branch;
        logic     alu_src_a;
        logic     alu_src_b;
        alu_op_t  alu_control;
    } de_ctrl_t;

    typedef struct packed {
        de_ctrl_t  ectl;
        imm_type_t imm_type;
    } ctrl_t;

    function automatic int unsigned mt_bits_threads(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic alu_op_t alu_dec(input logic [2:0] funct3, input logic funct7b5,
                                        input logic is_r);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit.sv
// RV32I main decoder: opcode/funct fields to datapath control.
module control_unit
    import mt_core_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_LOAD: begin
                ctrl.ectl.reg_write = 1'b1;
                ctrl.ectl.res_src   = RES_MEM;
                ctrl.ectl.alu_src_b = 1'b1;
            end
            OP_STORE: begin
                ctrl.ectl.mem_write = 1'b1;
                ctrl.ectl.alu_src_b = 1'b1;
                ctrl.imm_type       = IMM_S;
            end
            OP_R: begin
                ctrl.ectl.reg_write   = 1'b1;
                ctrl.ectl.alu_control = alu_dec(funct3, funct7b5, 1'b1);
            end
            OP_I: begin
                ctrl.ectl.reg_write   = 1'b1;
                ctrl.ectl.alu_src_b   = 1'b1;
                ctrl.ectl.alu_control = alu_dec(funct3, funct7b5, 1'b0);
            end
            OP_BRANCH: begin
                ctrl.ectl.branch      = 1'b1;
                ctrl.ectl.alu_control = ALU_SUB;
                ctrl.imm_type         = IMM_B;
            end
            OP_JAL: begin
                ctrl.ectl.reg_write = 1'b1;
                ctrl.ectl.res_src   = RES_PC4;
                ctrl.ectl.jump      = 1'b1;
                ctrl.ectl.alu_src_a = 1'b1;
                ctrl.ectl.alu_src_b = 1'b1;
                ctrl.imm_type       = IMM_J;
            end
            OP_JALR: begin
                ctrl.ectl.reg_write = 1'b1;
                ctrl.ectl.res_src   = RES_PC4;
                ctrl.ectl.jump      = 1'b1;
                ctrl.ectl.alu_src_b = 1'b1;
            end
            OP_LUI: begin
                ctrl.ectl.reg_write   = 1'b1;
                ctrl.ectl.alu_src_b   = 1'b1;
                ctrl.ectl.alu_control = ALU_LUI;
                ctrl.imm_type         = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.ectl.reg_write = 1'b1;
                ctrl.ectl.alu_src_a = 1'b1;
                ctrl.ectl.alu_src_b = 1'b1;
                ctrl.imm_type       = IMM_U;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_ext.sv
// Immediate extraction and sign extension for the RV32I formats.
module imm_ext
    import mt_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:7]           instr,
    input  imm_type_t             imm_type,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_WIDTH'(imm32);

endmodule

// File: rtl/mt_reg_file.sv
// Per-thread register file, two thread groups; x0 reads as zero.
module mt_reg_file
    import mt_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_THREADS  = 4,
    localparam int unsigned BITS_THREADS = mt_bits_threads(NUM_THREADS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tgrp,
    input  logic [BITS_THREADS-1:0] rtid,
    input  logic [4:0]              ra1,
    input  logic [4:0]              ra2,
    output logic [DATA_WIDTH-1:0]   rd1_c,
    output logic [DATA_WIDTH-1:0]   rd2_c,
    input  logic                    we,
    input  logic [BITS_THREADS-1:0] wtid,
    input  logic [4:0]              wa,
    input  logic [DATA_WIDTH-1:0]   wd
);

    localparam int unsigned NUM_CTX = 2 * NUM_THREADS;

    logic [NUM_CTX-1:0][NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0)
            regs_d[{tgrp, wtid}][wa] = wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    assign rd1_c = regs_q[{tgrp, rtid}][ra1];
    assign rd2_c = regs_q[{tgrp, rtid}][ra2];

endmodule

// File: rtl/mt_scoreboard.sv
// Per-thread register busy bits: two read ports, one set, two clears; set wins.
module mt_scoreboard
    import mt_core_pkg::*;
#(
    parameter int unsigned NUM_THREADS  = 4,
    localparam int unsigned BITS_THREADS = mt_bits_threads(NUM_THREADS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BITS_THREADS-1:0] rd_tid,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    output logic                    busy1_c,
    output logic                    busy2_c,
    input  logic                    set_en,
    input  logic [BITS_THREADS-1:0] set_tid,
    input  logic [4:0]              set_rd,
    input  logic                    clr_a_en,
    input  logic [BITS_THREADS-1:0] clr_a_tid,
    input  logic [4:0]              clr_a_rd,
    input  logic                    clr_b_en,
    input  logic [BITS_THREADS-1:0] clr_b_tid,
    input  logic [4:0]              clr_b_rd
);

    logic [NUM_THREADS-1:0][NUM_REGS-1:0] busy_q, busy_d;

    // Clears first so a same-cycle set of the same bit survives.
    always_comb begin
        busy_d = busy_q;
        if (clr_a_en) busy_d[clr_a_tid][clr_a_rd] = 1'b0;
        if (clr_b_en) busy_d[clr_b_tid][clr_b_rd] = 1'b0;
        if (set_en && set_rd != 5'd0) busy_d[set_tid][set_rd] = 1'b1;
        for (int t = 0; t < NUM_THREADS; t++) busy_d[t][0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy1_c = busy_q[rd_tid][rs1];
    assign busy2_c = busy_q[rd_tid][rs2];

endmodule

// File: rtl/mt_decode_stage.sv
// Registered decode stage: decode + operand read with RAW scoreboard, per-thread
// flush and optional write-back bypass, feeding a valid/ready D/E register.
module mt_decode_stage
    import mt_core_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_THREADS   = 4,
    parameter bit          BYPASS_EN     = 1'b1,
    localparam int unsigned BITS_THREADS = mt_bits_threads(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_f,
    output logic                     ready_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    input  logic [DATA_WIDTH-1:0]    instr_f,
    input  logic [BITS_THREADS-1:0]  tid_f,
    input  logic                     tgrp,
    input  logic                     reg_write_w,
    input  logic                     sb_clr_w,
    input  logic [4:0]               rd_w,
    input  logic [BITS_THREADS-1:0]  tid_w,
    input  logic [DATA_WIDTH-1:0]    result_w,
    input  logic                     flush_valid,
    input  logic [BITS_THREADS-1:0]  flush_tid,
    output logic                     valid_e,
    input  logic                     ready_e,
    output logic                     reg_write_e,
    output logic                     mem_write_e,
    output logic                     jump_e,
    output logic                     branch_e,
    output logic                     alu_src_a_e,
    output logic                     alu_src_b_e,
    output logic [1:0]               res_src_e,
    output logic [3:0]               alu_control_e,
    output logic [2:0]               funct3_e,
    output logic [DATA_WIDTH-1:0]    rd1_e,
    output logic [DATA_WIDTH-1:0]    rd2_e,
    output logic [DATA_WIDTH-1:0]    imm_val_e,
    output logic [ADDRESS_WIDTH-1:0] pc_e,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic [4:0]               rd_e,
    output logic [4:0]               rs1_e,
    output logic [4:0]               rs2_e,
    output logic [BITS_THREADS-1:0]  tid_e
);

    logic [4:0]            rs1_f, rs2_f, rd_f;
    ctrl_t                 ctrl_f;
    logic [DATA_WIDTH-1:0] imm_f, rf_rd1, rf_rd2, opa_f, opb_f;
    logic                  busy1, busy2, byp1, byp2, hazard, kill_e, accept;

    logic                     valid_q, valid_d;
    de_ctrl_t                 ectl_q, ectl_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0]    rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, pc4_q, pc4_d;
    logic [4:0]               rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [BITS_THREADS-1:0]  tid_q, tid_d;

    assign rs1_f = instr_f[19:15];
    assign rs2_f = instr_f[24:20];
    assign rd_f  = instr_f[11:7];

    control_unit u_ctrl (
        .op       (instr_f[6:0]),
        .funct3   (instr_f[14:12]),
        .funct7b5 (instr_f[30]),
        .ctrl     (ctrl_f)
    );

    imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm (
        .instr    (instr_f[31:7]),
        .imm_type (ctrl_f.imm_type),
        .imm      (imm_f)
    );

    mt_reg_file #(.DATA_WIDTH(DATA_WIDTH), .NUM_THREADS(NUM_THREADS)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .tgrp  (tgrp),
        .rtid  (tid_f),
        .ra1   (rs1_f),
        .ra2   (rs2_f),
        .rd1_c (rf_rd1),
        .rd2_c (rf_rd2),
        .we    (reg_write_w),
        .wtid  (tid_w),
        .wa    (rd_w),
        .wd    (result_w)
    );

    mt_scoreboard #(.NUM_THREADS(NUM_THREADS)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_tid    (tid_f),
        .rs1       (rs1_f),
        .rs2       (rs2_f),
        .busy1_c   (busy1),
        .busy2_c   (busy2),
        .set_en    (accept && ctrl_f.ectl.reg_write),
        .set_tid   (tid_f),
        .set_rd    (rd_f),
        .clr_a_en  ((reg_write_w || sb_clr_w) && rd_w != 5'd0),
        .clr_a_tid (tid_w),
        .clr_a_rd  (rd_w),
        .clr_b_en  (kill_e && ectl_q.reg_write),
        .clr_b_tid (tid_q),
        .clr_b_rd  (rd_q)
    );

    // A write-back to the same thread/register this cycle satisfies the read.
    assign byp1 = BYPASS_EN && reg_write_w && tid_w == tid_f && rd_w == rs1_f && rs1_f != 5'd0;
    assign byp2 = BYPASS_EN && reg_write_w && tid_w == tid_f && rd_w == rs2_f && rs2_f != 5'd0;
    assign opa_f = byp1 ? result_w : rf_rd1;
    assign opb_f = byp2 ? result_w : rf_rd2;

    assign hazard  = valid_f && ((busy1 && !byp1) || (busy2 && !byp2));
    assign kill_e  = flush_valid && valid_q && flush_tid == tid_q;
    assign ready_f = !rst && (!valid_q || ready_e || kill_e) && !hazard;
    assign accept  = valid_f && ready_f && !(flush_valid && flush_tid == tid_f);
    assign valid_e = valid_q && !kill_e;

    always_comb begin
        valid_d  = valid_q;
        ectl_d   = ectl_q;
        funct3_d = funct3_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        pc4_d    = pc4_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        tid_d    = tid_q;
        if (accept) begin
            valid_d  = 1'b1;
            ectl_d   = ctrl_f.ectl;
            funct3_d = instr_f[14:12];
            rd1_d    = opa_f;
            rd2_d    = opb_f;
            imm_d    = imm_f;
            pc_d     = pc_f;
            pc4_d    = pc_plus4_f;
            rd_d     = rd_f;
            rs1_d    = rs1_f;
            rs2_d    = rs2_f;
            tid_d    = tid_f;
        end else if (ready_e || kill_e) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ectl_q   <= '0;
            funct3_q <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            pc4_q    <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            tid_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ectl_q   <= ectl_d;
            funct3_q <= funct3_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            tid_q    <= tid_d;
        end
    end

    assign reg_write_e   = ectl_q.reg_write;
    assign mem_write_e   = ectl_q.mem_write;
    assign jump_e        = ectl_q.jump;
    assign branch_e      = ectl_q.branch;
    assign alu_src_a_e   = ectl_q.alu_src_a;
    assign alu_src_b_e   = ectl_q.alu_src_b;
    assign res_src_e     = ectl_q.res_src;
    assign alu_control_e = ectl_q.alu_control;
    assign funct3_e      = funct3_q;
    assign rd1_e         = rd1_q;
    assign rd2_e         = rd2_q;
    assign imm_val_e     = imm_q;
    assign pc_e          = pc_q;
    assign pc_plus4_e    = pc4_q;
    assign rd_e          = rd_q;
    assign rs1_e         = rs1_q;
    assign rs2_e         = rs2_q;
    assign tid_e         = tid_q;

endmodule

// File: doc/mt_decode_stage.md
Name: mt_decode_stage

Overview:
Registered decode stage for the multithreaded RV32 core. Decodes one fetched instruction per cycle and reads operands from the per-thread register file. Holds the result in a D/E pipeline register behind a valid/ready handshake. Adds three things the combinational decode lacks: a per-thread register scoreboard (RAW stall), per-thread flush, and optional write-back bypass.

Parameters:
ADDRESS_WIDTH, 32, PC width
DATA_WIDTH, 32, register/immediate width
NUM_THREADS, 4, hardware threads (power of two, >=2); BITS_THREADS = $clog2(NUM_THREADS) is a localparam
BYPASS_EN, 1, 1 = forward result_w into operand reads in the same cycle; 0 = stall until the scoreboard bit clears

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
valid_f  in  1  fetch presents an instruction
ready_f  out  1  decode consumes the instruction this cycle
pc_f, pc_plus4_f  in  ADDRESS_WIDTH  fetch PC and PC+4
instr_f  in  DATA_WIDTH  instruction word
tid_f  in  BITS_THREADS  thread of instr_f
tgrp  in  1  register-file thread group, passed to mt_reg_file
reg_write_w  in  1  write-back write enable
sb_clr_w  in  1  write-back slot releases its reservation without writing (killed instruction)
rd_w  in  5  write-back destination
tid_w  in  BITS_THREADS  write-back thread
result_w  in  DATA_WIDTH  write-back data
flush_valid  in  1  flush request
flush_tid  in  BITS_THREADS  thread to flush
valid_e  out  1  D/E entry valid
ready_e  in  1  execute accepts the entry
reg_write_e, mem_write_e, jump_e, branch_e, alu_src_a_e, alu_src_b_e  out  1 each  registered control
res_src_e  out  2  registered result-source select
alu_control_e  out  4  registered ALU operation
funct3_e  out  3  registered funct3
rd1_e, rd2_e, imm_val_e  out  DATA_WIDTH  registered operands and immediate
pc_e, pc_plus4_e  out  ADDRESS_WIDTH  registered PCs
rd_e, rs1_e, rs2_e  out  5  registered register indices
tid_e  out  BITS_THREADS  registered thread

Behaviour:
- Reset (asynchronous): valid register = 0, every payload register = 0, all scoreboard bits = 0. Outputs are 0 during reset; ready_f = 1 once rst is low.
- Decode is combinational from instr_f, using control_unit and imm_ext. Register indices: rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
- Scoreboard: one busy bit per (thread, reg 1..31). Register x0 is never busy and never reserved.
- hazard = valid_f and (busy[tid_f][rs1] or busy[tid_f][rs2]).
  - With BYPASS_EN=1, a busy source is not a hazard when this cycle has reg_write_w=1, tid_w=tid_f and rd_w equal to that source.
  - Sources are checked even when the format does not use them (conservative).
- ready_f = (!valid_q or ready_e or kill_e) and !hazard.
  - kill_e = flush_valid and valid_q and flush_tid == tid_q.
- accept = valid_f and ready_f and !(flush_valid and flush_tid == tid_f). A flushed fetch instruction is consumed and discarded.
- Operand data:
  - mt_reg_file read (tid_f, rs).
  - Replaced by result_w when BYPASS_EN=1, reg_write_w=1, tid_w=tid_f, rd_w=rs and rs != 0.
- valid_e = valid_q and !kill_e. This is combinational masking, so a killed entry is never transferred even when ready_e=1.
- Next state:
  - On accept: load the payload and set valid_q=1. Latency is 1 cycle from accept to valid_e.
  - Else if ready_e or kill_e: valid_q=0.
  - Else: hold. Payload is stable while valid_e=1 and ready_e=0.
- Scoreboard set: on accept with reg_write_d=1 and rd != 0, set busy[tid_f][rd].
- Scoreboard clear: busy[tid_w][rd_w] on (reg_write_w or sb_clr_w), and busy[tid_q][rd_q] on kill_e when reg_write_q=1.
- Same-cycle set and clear of the same bit: set wins.
- Flush affects only flush_tid. Other threads' scoreboard bits and entries are untouched. Downstream stages release their killed reservations via sb_clr_w.
- Writes to x0 via rd_w are ignored by the register file and scoreboard.

Decomposition:
- Shared package/header mt_core_pkg: opcode constants, res_src and imm_type encodings, ALU control encodings, and the BITS_THREADS derivation.
- Sub-module mt_scoreboard (NUM_THREADS x 32 bits, two read ports, one set port, two clear ports, set-wins priority).
- control_unit, imm_ext and mt_reg_file are reused unchanged.

Test Plan:
- Reset: assert rst mid-stream with valid_e=1 -> valid_e=0, all outputs 0, scoreboard clear; after release ready_f=1.
- RAW stall: tid1 addi x5,x0,7 accepted -> valid_e next cycle with rd_e=5, imm_val_e=7. Then tid1 add x6,x5,x5 -> ready_f=0 until reg_write_w=1, tid_w=1, rd_w=5, result_w=7; with BYPASS_EN=1 accepted in that cycle with rd1_e=rd2_e=7, with BYPASS_EN=0 accepted one cycle later.
- Thread isolation: x5 busy for tid1; tid2 add x6,x5,x5 -> accepted immediately.
- Backpressure: ready_e=0 for 3 cycles with valid_e=1 -> payload unchanged, ready_f=0; ready_e=1 -> next instruction loads the following cycle.
- Flush: E holds tid1 addi x7 with ready_e=0; flush_valid=1, flush_tid=1 -> valid_e=0 same cycle, busy[1][7] cleared next cycle, tid1 reader of x7 not stalled. The same cycle's tid1 fetch instruction is dropped (ready_f=1, no load).
- Corner rules:
  - addi x0 reserves nothing.
  - sb_clr_w releases a bit without a register-file write.
  - Set and clear of the same bit in the same cycle -> bit remains 1.
